// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter sharing one uart_tx between requesters
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int HOLD_TIMEOUT = 1024,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         u_tx_data,
  output logic                          u_tx_valid,
  input  logic                          u_tx_ready,
  input  logic                          u_tx_done,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy,
  output logic                          byte_done,
  output logic                          hold_timeout
);

  localparam int            CW         = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
  localparam bit            TIMEOUT_EN = (HOLD_TIMEOUT != 0);
  localparam logic [CW-1:0] HOLD_LAST  = (HOLD_TIMEOUT > 0) ? CW'(HOLD_TIMEOUT - 1) : '1;
  localparam logic [CW-1:0] HOLD_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]          grant_q, grant_d;
  logic                    last_q, last_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic                    byte_done_q, byte_done_d;
  logic                    hold_timeout_q, hold_timeout_d;
  logic                    busy_q, busy_d;
  logic [CW-1:0]           hold_cnt_q, hold_cnt_d;

  logic                    pick_found;
  logic [IDW-1:0]          pick_idx;
  logic                    owner_valid;
  logic                    hold_expire;
  logic                    accept;
  logic [IDW-1:0]          acc_idx;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return IDW'(s);
  endfunction

  // Scan downward so the lowest offset from rr_ptr is written last and wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_add(rr_ptr_q, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  assign owner_valid = req_valid[grant_q];
  assign hold_expire = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);
  assign accept      = ((state_q == S_IDLE) && pick_found) || ((state_q == S_HOLD) && owner_valid);
  assign acc_idx     = (state_q == S_HOLD) ? grant_q : pick_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      grant_q        <= '0;
      last_q         <= 1'b0;
      tx_data_q      <= '0;
      tx_valid_q     <= 1'b0;
      req_ready_q    <= '0;
      byte_done_q    <= 1'b0;
      hold_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
      hold_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_q        <= grant_d;
      last_q         <= last_d;
      tx_data_q      <= tx_data_d;
      tx_valid_q     <= tx_valid_d;
      req_ready_q    <= req_ready_d;
      byte_done_q    <= byte_done_d;
      hold_timeout_q <= hold_timeout_d;
      busy_q         <= busy_d;
      hold_cnt_q     <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_found) state_d = S_ISSUE;
      S_ISSUE: if (u_tx_ready) state_d = S_WAIT;
      S_WAIT:  if (u_tx_done) state_d = last_q ? S_IDLE : S_HOLD;
      S_HOLD: begin
        if (owner_valid)      state_d = S_ISSUE;
        else if (hold_expire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    grant_d        = grant_q;
    last_d         = last_q;
    tx_data_d      = tx_data_q;
    tx_valid_d     = tx_valid_q;
    hold_cnt_d     = hold_cnt_q;
    req_ready_d    = '0;
    byte_done_d    = 1'b0;
    hold_timeout_d = 1'b0;
    busy_d         = (state_d != S_IDLE);
    if (accept) begin
      grant_d              = acc_idx;
      tx_data_d            = req_data[acc_idx*DATA_WIDTH +: DATA_WIDTH];
      last_d               = req_last[acc_idx];
      req_ready_d[acc_idx] = 1'b1;
      tx_valid_d           = 1'b1;
    end
    case (state_q)
      S_ISSUE: if (u_tx_ready) tx_valid_d = 1'b0;
      S_WAIT: begin
        if (u_tx_done) begin
          byte_done_d = 1'b1;
          if (last_q) rr_ptr_d = wrap_add(grant_q, 1);
          else        hold_cnt_d = '0;
        end
      end
      S_HOLD: begin
        // An owner byte arriving on the expiry edge wins over the timeout.
        if (!owner_valid) begin
          if (hold_expire) begin
            hold_timeout_d = 1'b1;
            rr_ptr_d       = wrap_add(grant_q, 1);
          end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ready    = req_ready_q;
  assign u_tx_data    = tx_data_q;
  assign u_tx_valid   = tx_valid_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign byte_done    = byte_done_q;
  assign hold_timeout = hold_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int HT = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [DW-1:0]   u_tx_data;
  logic            u_tx_valid;
  logic            u_tx_ready = 1'b1;
  logic            u_tx_done = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            byte_done;
  logic            hold_timeout;

  int        checks = 0;
  int        failures = 0;
  int        hs_cnt = 0;
  int        hs_before;
  logic [7:0] line_q[$];
  logic [7:0] exp_line[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .HOLD_TIMEOUT(HT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .u_tx_data(u_tx_data), .u_tx_valid(u_tx_valid), .u_tx_ready(u_tx_ready), .u_tx_done(u_tx_done),
    .grant_id(grant_id), .busy(busy), .byte_done(byte_done), .hold_timeout(hold_timeout)
  );

  always @(posedge clk) begin
    if (!rst && u_tx_valid && u_tx_ready) begin
      line_q.push_back(u_tx_data);
      hs_cnt <= hs_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic l);
    req_valid[i] = 1'b1;
    req_data[i*DW +: DW] = d;
    req_last[i] = l;
  endtask

  task automatic accept(input string tag, input int g, input logic [7:0] d);
    logic [NR-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    step();
    chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
    chk({tag, "_grant"}, 32'(grant_id), 32'(g));
    chk({tag, "_valid"}, 32'(u_tx_valid), 32'd1);
    chk({tag, "_data"}, 32'(u_tx_data), 32'(d));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_byte(input string tag, input logic lst);
    step();
    chk({tag, "_valid_clr"}, 32'(u_tx_valid), 32'd0);
    chk({tag, "_ready_pulse"}, 32'(req_ready), 32'd0);
    tick(2);
    chk({tag, "_no_early_done"}, 32'(byte_done), 32'd0);
    u_tx_done = 1'b1;
    step();
    u_tx_done = 1'b0;
    chk({tag, "_byte_done"}, 32'(byte_done), 32'd1);
    chk({tag, "_busy_after"}, 32'(busy), 32'(!lst));
  endtask

  initial begin
    // reset state
    tick(2);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_valid", 32'(u_tx_valid), 32'd0);
    chk("rst_data", 32'(u_tx_data), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_flags", 32'({byte_done, hold_timeout}), 32'd0);
    rst = 1'b0;
    step();

    // single byte from req1
    set_req(1, 8'hA5, 1'b1);
    accept("t1", 1, 8'hA5);
    req_valid = '0;
    finish_byte("t1", 1'b1);
    step();
    chk("t1_done_single", 32'(byte_done), 32'd0);
    chk("t1_hs_count", 32'(hs_cnt), 32'd1);

    // fairness: req0/req2 always valid, rr_ptr=2 so req2 first
    set_req(0, 8'h10, 1'b1);
    set_req(2, 8'h20, 1'b1);
    accept("t2a", 2, 8'h20); finish_byte("t2a", 1'b1);
    accept("t2b", 0, 8'h10); finish_byte("t2b", 1'b1);
    accept("t2c", 2, 8'h20); finish_byte("t2c", 1'b1);
    accept("t2d", 0, 8'h10);
    req_valid = '0;
    finish_byte("t2d", 1'b1);

    // packet lock: req1 sends 3 bytes, req0 waits throughout
    set_req(1, 8'h11, 1'b0);
    set_req(0, 8'h44, 1'b1);
    accept("t3a", 1, 8'h11);
    set_req(1, 8'h22, 1'b0);
    finish_byte("t3a", 1'b0);
    accept("t3b", 1, 8'h22);
    set_req(1, 8'h33, 1'b1);
    finish_byte("t3b", 1'b0);
    accept("t3c", 1, 8'h33);
    req_valid[1] = 1'b0;
    finish_byte("t3c", 1'b1);
    accept("t3d", 0, 8'h44);
    req_valid[0] = 1'b0;
    finish_byte("t3d", 1'b1);

    // hold timeout: req2 stalls mid-packet, req3 pending
    set_req(2, 8'h55, 1'b0);
    set_req(3, 8'h66, 1'b1);
    accept("t4a", 2, 8'h55);
    req_valid[2] = 1'b0;
    finish_byte("t4a", 1'b0);
    tick(15);
    chk("t4_no_early_to", 32'(hold_timeout), 32'd0);
    chk("t4_still_busy", 32'(busy), 32'd1);
    step();
    chk("t4_timeout", 32'(hold_timeout), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    accept("t4b", 3, 8'h66);
    chk("t4_to_pulse", 32'(hold_timeout), 32'd0);
    req_valid[3] = 1'b0;
    finish_byte("t4b", 1'b1);

    // owner returns on the expiry edge: accept wins, no pulse
    set_req(2, 8'h55, 1'b0);
    accept("t4c", 2, 8'h55);
    req_valid[2] = 1'b0;
    finish_byte("t4c", 1'b0);
    tick(15);
    set_req(2, 8'h77, 1'b1);
    accept("t4d", 2, 8'h77);
    chk("t4d_no_to", 32'(hold_timeout), 32'd0);
    req_valid[2] = 1'b0;
    finish_byte("t4d", 1'b1);

    // backpressure in ISSUE
    u_tx_ready = 1'b0;
    set_req(0, 8'h5A, 1'b1);
    accept("t5", 0, 8'h5A);
    req_valid[0] = 1'b0;
    hs_before = hs_cnt;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_hold_valid", 32'(u_tx_valid), 32'd1);
      chk("t5_hold_data", 32'(u_tx_data), 32'h5A);
    end
    u_tx_ready = 1'b1;
    finish_byte("t5", 1'b1);
    chk("t5_one_xfer", 32'(hs_cnt - hs_before), 32'd1);

    // reset while in WAIT with a packet locked
    set_req(1, 8'h99, 1'b0);
    accept("t6a", 1, 8'h99);
    req_valid = '0;
    step();
    chk("t6_in_wait", 32'(u_tx_valid), 32'd0);
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_grant", 32'(grant_id), 32'd0);
    chk("t6_async_data", 32'(u_tx_data), 32'd0);
    chk("t6_async_pulses", 32'({req_ready, byte_done, hold_timeout}), 32'd0);
    tick(2);
    rst = 1'b0;
    u_tx_done = 1'b1;
    step();
    u_tx_done = 1'b0;
    chk("t6_no_stale_done", 32'(byte_done), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    set_req(0, 8'h01, 1'b1);
    set_req(1, 8'h02, 1'b1);
    accept("t6b", 0, 8'h01);
    req_valid[0] = 1'b0;
    finish_byte("t6b", 1'b1);
    accept("t6c", 1, 8'h02);
    req_valid[1] = 1'b0;
    finish_byte("t6c", 1'b1);

    // full line order
    exp_line = '{8'hA5, 8'h20, 8'h10, 8'h20, 8'h10, 8'h11, 8'h22, 8'h33, 8'h44,
                 8'h55, 8'h66, 8'h55, 8'h77, 8'h5A, 8'h99, 8'h01, 8'h02};
    chk("line_len", 32'(line_q.size()), 32'(exp_line.size()));
    for (int i = 0; i < exp_line.size(); i++) begin
      if (i < line_q.size()) chk($sformatf("line_%0d", i), 32'(line_q[i]), 32'(exp_line[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
